icache_dm_refill: RTL

// - Parametrised direct-mapped instruction cache between the fetch unit and the memory arbiter.
// - Lookup is combinational on fetch_addr, so a hit returns data in the same cycle.
// - A miss starts a line refill FSM that fetches the whole line word-by-word from the arbiter.
// - Adds multi-word lines, a refill engine, flush and abort that the single-word cache lacks.

---
 rtl/icache_dm_refill.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/icache_dm_refill.sv
// rtl/icache_dm_refill.sv - direct-mapped instruction cache with line refill engine
//
// Purpose: direct-mapped instruction cache between the fetch unit and the memory
// arbiter. Lookup is combinational on fetch_addr, so a hit returns data in the same
// cycle. A miss starts a refill FSM that reads the whole line word-by-word, in order
// from offset 0.
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   rdy_in                   global enable; low freezes all state
//   fetch_valid, fetch_addr  lookup request (byte address, bits [1:0] ignored)
//   fetch_hit, fetch_data    same-cycle hit and instruction word (0 on no hit)
//   fetch_abort              branch redirect; the refill completes regardless
//   flush                    invalidate all lines
//   mem_req, mem_addr        word read request to the arbiter
//   mem_ready, mem_data      returned word for the current mem_addr
//   busy                     refill in progress
//   perf_hits, perf_misses   hit / miss counters, only with ICACHE_PERF_CNT_EN
//
// Optional feature macro: ICACHE_PERF_CNT_EN
module icache_dm_refill #(
  parameter int INDEX_BITS    = 6,
  parameter int OFFSET_W_BITS = 2,
  parameter int ADDR_W        = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_hit,
  output logic [31:0]       fetch_data,
  input  logic              fetch_abort,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_data,
  output logic              busy
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
`endif
);

  localparam int TAG_W  = ADDR_W - INDEX_BITS - OFFSET_W_BITS - 2;
  localparam int LINE_W = ADDR_W - OFFSET_W_BITS - 2;
  localparam int LINES  = 1 << INDEX_BITS;
  localparam int WORDS  = 1 << OFFSET_W_BITS;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  localparam logic [OFFSET_W_BITS-1:0] CNT_LAST = '1;
  localparam logic [OFFSET_W_BITS-1:0] CNT_ONE  = OFFSET_W_BITS'(1);

  logic [0:0]               state_q, state_d;
  logic [OFFSET_W_BITS-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0]        line_q, line_d;   // line address being refilled
  logic                     drop_q, drop_d;   // flush seen during refill: do not install
  logic [LINES-1:0]         valid_q, valid_d;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];

  logic [OFFSET_W_BITS-1:0] f_word;
  logic [INDEX_BITS-1:0]    f_idx;
  logic [TAG_W-1:0]         f_tag;
  logic [INDEX_BITS-1:0]    r_idx;
  logic [TAG_W-1:0]         r_tag;
  logic                     hit;
  logic                     miss;
  logic                     fill;
  logic                     unused_bits;

  assign f_word = fetch_addr[OFFSET_W_BITS+1:2];
  assign f_idx  = fetch_addr[OFFSET_W_BITS+2 +: INDEX_BITS];
  assign f_tag  = fetch_addr[ADDR_W-1 -: TAG_W];
  assign r_idx  = line_q[INDEX_BITS-1:0];
  assign r_tag  = line_q[LINE_W-1 -: TAG_W];

  // Abort needs no state: the refill always completes and installs the line.
  assign unused_bits = ^{fetch_abort, fetch_addr[1:0]};

  // Flush and reset both force the lookup to miss in the cycle they are asserted.
  assign hit = fetch_valid & valid_q[f_idx] & (tag_mem[f_idx] == f_tag) &
               (state_q == S_IDLE) & ~flush & ~rst_in;
  assign miss = fetch_valid & ~hit & ~flush;

  assign fetch_hit  = hit;
  assign fetch_data = hit ? data_mem[{f_idx, f_word}] : 32'h0;
  assign mem_req    = (state_q == S_REFILL) & ~rst_in;
  assign mem_addr   = mem_req ? {line_q, cnt_q, 2'b00} : '0;
  assign busy       = (state_q != S_IDLE) & ~rst_in;

  // mem_ready outside a request (or while frozen) is ignored.
  assign fill = mem_req & mem_ready & rdy_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if (miss) begin
            line_d         = fetch_addr[ADDR_W-1:OFFSET_W_BITS+2];
            cnt_d          = '0;
            state_d        = S_REFILL;
            // The resident line is overwritten word by word; drop it now so a
            // dropped refill cannot leave the old valid bit paired with the new tag.
            valid_d[f_idx] = 1'b0;
          end
        end
        S_REFILL: begin
          if (flush) begin
            drop_d = 1'b1;
          end
          if (fill) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              state_d = S_IDLE;
              drop_d  = 1'b0;
              if (!drop_q && !flush) begin
                valid_d[r_idx] = 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (flush) begin
        valid_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      drop_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk_in) begin
    if (fill) begin
      data_mem[{r_idx, cnt_q}] <= mem_data;
      if (cnt_q == CNT_LAST) begin
        tag_mem[r_idx] <= r_tag;
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_misses_q, perf_misses_d;

  always_comb begin
    perf_hits_d   = perf_hits_q;
    perf_misses_d = perf_misses_q;
    if (rdy_in) begin
      if (hit) begin
        perf_hits_d = perf_hits_q + 32'd1;
      end
      if ((state_q == S_IDLE) && miss) begin
        perf_misses_d = perf_misses_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_hits_q   <= 32'd0;
      perf_misses_q <= 32'd0;
    end else begin
      perf_hits_q   <= perf_hits_d;
      perf_misses_q <= perf_misses_d;
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
`endif

endmodule
